// File: rtl/rotate_arbiter.sv
// Round-robin shares one 32-bit left-rotate stage among NUM_REQ requesters; result is registered, 1-cycle latency.
// resp_ready low while holding a result stalls all grants; ROTATE_ARB_STATS_EN adds grant_count and stall outputs.
module rotate_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_data,
  input  logic [5*NUM_REQ-1:0]    req_shift,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [31:0]             resp_data,
  output logic [ID_W-1:0]         resp_id
`ifdef ROTATE_ARB_STATS_EN
  ,
  output logic [15:0]             grant_count,
  output logic                    stall
`endif
);

  localparam int PW = ID_W + 1;
  localparam logic [PW-1:0]   NUM_REQ_W = PW'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;

  logic [31:0]     data_arr  [NUM_REQ];
  logic [4:0]      shift_arr [NUM_REQ];

  logic            can_accept;
  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic            xfer;
  logic [31:0]     sel_data;
  logic [4:0]      sel_shift;
  logic [31:0]     rot_data;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i]  = req_data[32*i +: 32];
    assign shift_arr[i] = req_shift[5*i +: 5];
  end

  assign can_accept = (state == EMPTY) || resp_ready;

  // Priority search starts at rr_ptr and wraps; the extra sum bit keeps the wrap compare exact.
  always_comb begin
    logic [PW-1:0] sum;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + PW'(k);
      if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
      if (!grant_vld && req_valid[sum[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = sum[ID_W-1:0];
      end
    end
  end

  assign xfer      = grant_vld && can_accept;
  assign req_ready = xfer ? (NUM_REQ'(1) << grant_idx) : '0;

  assign sel_data  = data_arr[grant_idx];
  assign sel_shift = shift_arr[grant_idx];

  always_comb begin
    rot_data = sel_data;
    if (sel_shift[0]) rot_data = {rot_data[30:0], rot_data[31]};
    if (sel_shift[1]) rot_data = {rot_data[29:0], rot_data[31:30]};
    if (sel_shift[2]) rot_data = {rot_data[27:0], rot_data[31:28]};
    if (sel_shift[3]) rot_data = {rot_data[23:0], rot_data[31:24]};
    if (sel_shift[4]) rot_data = {rot_data[15:0], rot_data[31:16]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      rr_ptr     <= '0;
    end else if (xfer) begin
      state      <= FULL;
      resp_valid <= 1'b1;
      resp_data  <= rot_data;
      resp_id    <= grant_idx;
      rr_ptr     <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
    end else if (state == FULL && resp_ready) begin
      state      <= EMPTY;
      resp_valid <= 1'b0;
    end
  end

`ifdef ROTATE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_count <= '0;
      stall       <= 1'b0;
    end else begin
      if (xfer) grant_count <= grant_count + 16'd1;
      stall <= resp_valid && !resp_ready;
    end
  end
`endif

endmodule

// File: tb/tb_rotate_arbiter.sv
// Directed bench for rotate_arbiter: vector table for the rotate path plus sequences for fairness, backpressure and reset.
module tb_rotate_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_data;
  logic [5*NUM_REQ-1:0]  req_shift;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_data;
  logic [ID_W-1:0]       resp_id;
`ifdef ROTATE_ARB_STATS_EN
  logic [15:0]           grant_count;
  logic                  stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rotate_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_shift  (req_shift),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
`ifdef ROTATE_ARB_STATS_EN
    ,
    .grant_count(grant_count),
    .stall      (stall)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [4:0]  shift;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  // Requester k in the fairness runs sends 1<<(4k) rotated by k, giving 1<<(5k).
  logic [31:0] rr_exp [4];

  initial begin
    vecs[0] = '{2, 32'h8000_0001, 5'd1,  32'h0000_0003};
    vecs[1] = '{0, 32'h1234_5678, 5'd8,  32'h3456_7812};
    vecs[2] = '{1, 32'hDEAD_BEEF, 5'd16, 32'hBEEF_DEAD};
    vecs[3] = '{2, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[4] = '{1, 32'hF000_0000, 5'd4,  32'h0000_000F};
    vecs[5] = '{3, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5};
    rr_exp[0] = 32'h0000_0001;
    rr_exp[1] = 32'h0000_0020;
    rr_exp[2] = 32'h0000_0400;
    rr_exp[3] = 32'h0000_8000;

    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_shift  = '0;
    resp_ready = 1'b0;
    #1;
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    resp_ready = 1'b1;

    for (int c = 0; c < 3; c++) begin
      tick();
      check("idle_resp_valid", 32'(resp_valid), 32'd0);
      check("idle_resp_data",  resp_data,       32'd0);
      check("idle_resp_id",    32'(resp_id),    32'd0);
      check("idle_req_ready",  32'(req_ready),  32'd0);
    end

    // Single-requester rotate vectors
    for (int v = 0; v < 6; v++) begin
      req_valid = '0;
      req_valid[vecs[v].id] = 1'b1;
      req_data[32*vecs[v].id +: 32] = vecs[v].data;
      req_shift[5*vecs[v].id +: 5]  = vecs[v].shift;
      #1;
      check("vec_req_ready", 32'(req_ready), 32'(1) << vecs[v].id);
      tick();
      check("vec_resp_valid", 32'(resp_valid), 32'd1);
      check("vec_resp_data",  resp_data,       vecs[v].exp);
      check("vec_resp_id",    32'(resp_id),    32'(vecs[v].id));
    end

    // Last vector came from requester 3, so the pointer is back at 0.
    req_valid = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[32*i +: 32] = 32'h1 << (4*i);
      req_shift[5*i +: 5]  = 5'(i);
    end
    for (int c = 0; c < 6; c++) begin
      #1;
      check("rr_req_ready", 32'(req_ready), 32'(1) << (c % 4));
      tick();
      check("rr_resp_id",   32'(resp_id),   32'(c % 4));
      check("rr_resp_data", resp_data,      rr_exp[c % 4]);
    end

    // Backpressure: requester 1's result held, pointer at 2.
    resp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_req_ready",  32'(req_ready),  32'd0);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_data",  resp_data,       rr_exp[1]);
      check("bp_resp_id",    32'(resp_id),    32'd1);
      tick();
    end
    check("bp_hold_data", resp_data, rr_exp[1]);
    resp_ready = 1'b1;
    #1;
    check("bp_release_req_ready", 32'(req_ready), 32'b0100);
    tick();
    check("bp_release_id",    32'(resp_id),    32'd2);
    check("bp_release_data",  resp_data,       rr_exp[2]);
    check("bp_release_valid", 32'(resp_valid), 32'd1);

    // Asynchronous reset while FULL with requests pending (pointer at 3).
    resp_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_resp_data",  resp_data,       32'd0);
    check("arst_resp_id",    32'(resp_id),    32'd0);
    #2;
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'b0001);
    tick();
    check("post_rst_resp_id",    32'(resp_id),    32'd0);
    check("post_rst_resp_data",  resp_data,       rr_exp[0]);
    check("post_rst_resp_valid", 32'(resp_valid), 32'd1);

    req_valid = '0;
    tick();
    check("drain_resp_valid", 32'(resp_valid), 32'd0);
    check("drain_req_ready",  32'(req_ready),  32'd0);

`ifdef ROTATE_ARB_STATS_EN
    check("stats_count_after_rst", 32'(grant_count), 32'd1);
    req_valid  = 4'b0001;
    resp_ready = 1'b1;
    repeat (69999) @(posedge clk);
    #1;
    check("stats_count_wrap", 32'(grant_count), 32'd4464);
    check("stats_stall_idle", 32'(stall), 32'd0);
    req_valid  = '0;
    resp_ready = 1'b0;
    tick();
    check("stats_stall_high", 32'(stall), 32'd1);
    resp_ready = 1'b1;
    tick();
    check("stats_stall_low", 32'(stall), 32'd0);
    check("stats_count_hold", 32'(grant_count), 32'd4464);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rotate_arbiter.md
# rotate_arbiter

Shares one 32-bit left-rotate datapath between NUM_REQ requesters. Each requester presents a word and a 5-bit rotate amount over a valid/ready handshake. A round-robin arbiter grants one request per cycle, rotates it through a single internal left-rotate stage, and returns the result in an output register with a requester ID. The block sits between the front-end request sources and the downstream consumer of rotated words.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of resp_id; must equal ceil(log2(NUM_REQ)), minimum 1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester grant; at most one bit high
- req_data  input  32*NUM_REQ  word of requester i at bits [32*i+31:32*i]
- req_shift  input  5*NUM_REQ  rotate amount of requester i at bits [5*i+4:5*i]
- resp_valid  output  1  result valid
- resp_ready  input  1  consumer accepts result
- resp_data  output  32  rotated word
- resp_id  output  ID_W  index of the requester that produced resp_data

## Operation
- Rotate: resp_data = (data << shift) | (data >> (32 - shift)), mod 32. Decompose as 5 conditional stages of 1, 2, 4, 8 and 16 bits. shift = 0 passes the word unchanged. No sign or fill bits.
- Output register states:
  - EMPTY: resp_valid = 0.
  - FULL: resp_valid = 1. resp_data and resp_id are held stable until resp_ready = 1.
- can_accept = EMPTY | (FULL & resp_ready).
- Arbitration: when can_accept is high, grant the first i with req_valid[i] = 1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready has the grant bit set. All other bits are 0.
  - req_ready is combinational from req_valid, state and resp_ready.
  - When can_accept = 0, req_ready = 0.
- Transfer occurs when req_valid[i] & req_ready[i]. On the same clock edge:
  - The output register loads rotate(data_i, shift_i) and ID i.
  - The state becomes FULL.
  - rr_ptr becomes (i+1) mod NUM_REQ.
- FULL & resp_ready & no grant: the state becomes EMPTY.
- FULL & resp_ready & grant: the register reloads and stays FULL. This gives back-to-back throughput of 1 word per cycle.
- No grant: rr_ptr holds its value.
- A requester must hold data and shift stable while valid and not granted. Dropping req_valid without a grant is legal; the request is simply not taken.
- Reset values:
  - resp_valid = 0
  - resp_data = 0
  - resp_id = 0
  - rr_ptr = 0, so requester 0 has highest priority first
  - state = EMPTY
- Reset asserted mid-operation discards any held result immediately (asynchronously). No response is produced for it.

## Timing
- Latency: request accepted on edge N produces resp_valid high after edge N, i.e. 1 cycle.
- Throughput: 1 result per cycle while resp_ready = 1.
- Backpressure: resp_ready = 0 while FULL stalls all grants. The held result is unaffected.
- Fairness: with all requesters continuously valid and resp_ready = 1, grants rotate 0,1,2,…,NUM_REQ-1,0. Any valid requester is granted within NUM_REQ accepting cycles.
- Critical path: arbiter mux plus 5 rotate stages into the output register. No internal pipeline register.

## Configuration
- ROTATE_ARB_STATS_EN defined:
  - Adds output grant_count (16 bits): the number of accepted requests since reset.
  - Resets to 0 and increments by 1 on every transfer.
  - Wraps from 0xFFFF to 0x0000.
  - Adds output stall (1 bit), registered: high for the cycle after any cycle with resp_valid = 1 and resp_ready = 0. Resets to 0.
- Not defined: neither port nor its logic exists. All other behaviour is identical.

## Test plan
- Reset release with no requests: resp_valid = 0, resp_data = 0, resp_id = 0, req_ready = 0 at all times.
- Requester 2 sends 0x80000001, shift 1, resp_ready = 1: next cycle resp_data = 0x00000003, resp_id = 2. Also check:
  - 0x12345678, shift 8 -> 0x34567812
  - 0xDEADBEEF, shift 16 -> 0xBEEFDEAD
  - 0x00000001, shift 31 -> 0x80000000
  - 0xA5A5A5A5, shift 0 -> 0xA5A5A5A5
- All 4 requesters valid continuously, resp_ready = 1: resp_id sequence 0,1,2,3,0,1 on consecutive cycles, one req_ready bit per cycle.
- resp_ready held 0 for 5 cycles with a result FULL: resp_data/resp_id stay constant and req_ready = 0. Raising resp_ready yields the next grant on the same cycle, with no bubble.
- rst_n pulsed low while FULL and requests pending: resp_valid drops to 0 at once and rr_ptr returns to 0. After release, requester 0 is granted first.
- With ROTATE_ARB_STATS_EN: 70000 accepted requests -> grant_count = 70000 mod 65536 = 4464. One stalled cycle -> stall high exactly one cycle later.
